// File: rtl/udp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// udp_ctrl_pkg
// Shared definitions for the UDP loopback controller:
//   - ctrl_state_t : controller FSM state encoding (also the debug encoding)
//   - HDR_BYTES    : IP+UDP header bytes added to the payload length
//   - TX_IDLE      : ipsend tx_state value meaning "idle"
//   - len_ok()     : received-frame length sanity check
// ---------------------------------------------------------------------------
package udp_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2,
      ST_GAP   = 2'd3
   } ctrl_state_t;

   localparam int unsigned HDR_BYTES = 28;
   localparam logic [3:0]  TX_IDLE   = 4'd0;

   // Payload must be 1..max_payload and the IP total length must equal
   // payload + header. The sum is 17 bits wide so a payload close to 65535
   // cannot wrap around and falsely match a small total length.
   function automatic logic len_ok(input logic [15:0] data_len,
                                   input logic [15:0] total_len,
                                   input logic [15:0] max_payload,
                                   input logic [15:0] hdr_bytes);
      logic [16:0] sum;
      sum = {1'b0, data_len} + {1'b0, hdr_bytes};
      return (data_len != 16'd0) &&
             (data_len <= max_payload) &&
             ({1'b0, total_len} == sum);
   endfunction

endpackage

// File: rtl/udp_bank_slot.sv
// ---------------------------------------------------------------------------
// udp_bank_slot
// One half of the ping-pong frame RAM bookkeeping: a full flag plus the
// stored data/total lengths of the frame held in that bank.
// Ports:
//   e_rxc, reset_n         : clock, asynchronous active-low reset
//   set                    : store set_*_len and mark the bank full
//   clr                    : mark the bank empty (lengths are kept)
//   set_data_len/total_len : lengths captured on set
//   full                   : bank holds a frame awaiting transmission
//   data_len, total_len    : stored lengths
// ---------------------------------------------------------------------------
module udp_bank_slot
   import udp_ctrl_pkg::*;
(
   input  logic        e_rxc,
   input  logic        reset_n,
   input  logic        set,
   input  logic        clr,
   input  logic [15:0] set_data_len,
   input  logic [15:0] set_total_len,
   output logic        full,
   output logic [15:0] data_len,
   output logic [15:0] total_len
);

   // set and clr never hit the same slot in one cycle (set needs the bank
   // empty, clr needs it full); set is given priority regardless.
   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) begin
         full      <= 1'b0;
         data_len  <= 16'd0;
         total_len <= 16'd0;
      end else if (set) begin
         full      <= 1'b1;
         data_len  <= set_data_len;
         total_len <= set_total_len;
      end else if (clr) begin
         full      <= 1'b0;
      end
   end

endmodule

// File: rtl/udp_loopback_ctrl.sv
// ---------------------------------------------------------------------------
// udp_loopback_ctrl
// Sequences the UDP loopback path: received frames are queued in a two-bank
// ping-pong frame RAM, then handed to ipsend one at a time, in arrival order,
// with an enforced inter-frame gap. RAM writes are gated so a bank awaiting
// transmission is never overwritten.
// Ports:
//   e_rxc, reset_n     : clock, asynchronous active-low reset
//   data_receive       : 1-cycle pulse, frame fully written to RAM
//   rx_data_length     : payload bytes (valid with data_receive)
//   rx_total_length    : IP total length (valid with data_receive)
//   tx_state           : ipsend state (TX_IDLE = idle)
//   wr_bank, rd_bank   : RAM write / read address MSB
//   ram_wr_en          : RAM write gate, ~full[wr_bank]
//   tx_start           : start request to ipsend
//   tx_data_length     : payload length for ipsend
//   tx_total_length    : total length for ipsend
//   drop_cnt           : saturating count of dropped frames
//   ctrl_state         : FSM state (debug)
//
// Start handshake: tx_start is the request (valid) and is held high until
// ipsend acknowledges by leaving TX_IDLE; tx_start drops the cycle after the
// first non-idle tx_state is seen. tx_*_length are stable while tx_start is
// high and hold until the next frame is loaded. If no acknowledge arrives
// within ACK_TIMEOUT cycles the frame is abandoned and counted as a drop.
// ---------------------------------------------------------------------------
module udp_loopback_ctrl
   import udp_ctrl_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD = 1472,
   parameter int unsigned HDR_BYTES   = udp_ctrl_pkg::HDR_BYTES,
   parameter logic [3:0]  TX_IDLE     = udp_ctrl_pkg::TX_IDLE,
   parameter int unsigned ACK_TIMEOUT = 1024,
   parameter int unsigned MIN_GAP     = 12
)(
   input  logic        e_rxc,
   input  logic        reset_n,
   input  logic        data_receive,
   input  logic [15:0] rx_data_length,
   input  logic [15:0] rx_total_length,
   input  logic [3:0]  tx_state,
   output logic        wr_bank,
   output logic        rd_bank,
   output logic        ram_wr_en,
   output logic        tx_start,
   output logic [15:0] tx_data_length,
   output logic [15:0] tx_total_length,
   output logic [7:0]  drop_cnt,
   output logic [1:0]  ctrl_state
);

   localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
   localparam int GAP_W = $clog2(MIN_GAP + 1);

   ctrl_state_t state, next_state;

   logic [1:0]  full;
   logic [15:0] slot_data_len  [2];
   logic [15:0] slot_total_len [2];

   logic accept, reject;
   logic load, release_bank, timeout;

   logic [TO_W-1:0]  to_cnt;
   logic [GAP_W-1:0] gap_cnt;

   // ------------------------------------------------------------------
   // Receive side: accept into the current write bank if it is empty and
   // the lengths are sane; otherwise drop and keep wr_bank so the next
   // frame overwrites the same bank.
   // ------------------------------------------------------------------
   assign accept = data_receive && !full[wr_bank] &&
                   len_ok(rx_data_length, rx_total_length,
                          16'(MAX_PAYLOAD), 16'(HDR_BYTES));
   assign reject = data_receive && !accept;

   assign ram_wr_en = ~full[wr_bank];

   udp_bank_slot u_slot0 (
      .e_rxc         (e_rxc),
      .reset_n       (reset_n),
      .set           (accept && (wr_bank == 1'b0)),
      .clr           (release_bank && (rd_bank == 1'b0)),
      .set_data_len  (rx_data_length),
      .set_total_len (rx_total_length),
      .full          (full[0]),
      .data_len      (slot_data_len[0]),
      .total_len     (slot_total_len[0])
   );

   udp_bank_slot u_slot1 (
      .e_rxc         (e_rxc),
      .reset_n       (reset_n),
      .set           (accept && (wr_bank == 1'b1)),
      .clr           (release_bank && (rd_bank == 1'b1)),
      .set_data_len  (rx_data_length),
      .set_total_len (rx_total_length),
      .full          (full[1]),
      .data_len      (slot_data_len[1]),
      .total_len     (slot_total_len[1])
   );

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state   = state;
      load         = 1'b0;
      release_bank = 1'b0;
      timeout      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (full[rd_bank]) begin
               load       = 1'b1;
               next_state = ST_START;
            end
         end
         ST_START: begin
            // An acknowledge on the last allowed cycle still wins.
            if (tx_state != TX_IDLE) begin
               next_state = ST_BUSY;
            end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
               timeout      = 1'b1;
               release_bank = 1'b1;
               next_state   = ST_GAP;
            end
         end
         ST_BUSY: begin
            if (tx_state == TX_IDLE) begin
               release_bank = 1'b1;
               next_state   = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt == GAP_W'(MIN_GAP - 1)) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign tx_start   = (state == ST_START);
   assign ctrl_state = state;

   // Counters run only while their state persists and restart from 0 on
   // every entry, so START lasts at most ACK_TIMEOUT cycles and GAP exactly
   // MIN_GAP cycles.
   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt  <= '0;
         gap_cnt <= '0;
      end else begin
         to_cnt  <= (state == ST_START && next_state == ST_START) ? to_cnt + 1'b1 : '0;
         gap_cnt <= (state == ST_GAP && next_state == ST_GAP) ? gap_cnt + 1'b1 : '0;
      end
   end

   // ------------------------------------------------------------------
   // Bank pointers, output lengths, drop counter
   // ------------------------------------------------------------------
   logic [1:0] drop_inc;
   logic [8:0] drop_sum;

   assign drop_inc = {1'b0, reject} + {1'b0, timeout};
   assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};

   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) begin
         wr_bank         <= 1'b0;
         rd_bank         <= 1'b0;
         tx_data_length  <= 16'd0;
         tx_total_length <= 16'd0;
         drop_cnt        <= 8'd0;
      end else begin
         wr_bank <= wr_bank ^ accept;
         rd_bank <= rd_bank ^ release_bank;
         if (load) begin
            tx_data_length  <= rd_bank ? slot_data_len[1]  : slot_data_len[0];
            tx_total_length <= rd_bank ? slot_total_len[1] : slot_total_len[0];
         end
         drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      end
   end

endmodule

// File: tb/tb_udp_loopback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_udp_loopback_ctrl
// Directed and randomized checks of udp_loopback_ctrl. A reference model
// (frame queue with at most two pending entries, length rule from plain
// arithmetic) pushes expected tx lengths into exp_q on every accepted frame;
// a monitor pops and compares whenever tx_start rises.
// ---------------------------------------------------------------------------
module tb_udp_loopback_ctrl;

  localparam int MAX_PAYLOAD = 1472;
  localparam int HDR_BYTES   = 28;
  localparam int ACK_TIMEOUT = 1024;
  localparam int MIN_GAP     = 12;

  logic        e_rxc;
  logic        reset_n;
  logic        data_receive;
  logic [15:0] rx_data_length;
  logic [15:0] rx_total_length;
  logic [3:0]  tx_state;
  logic        wr_bank, rd_bank, ram_wr_en, tx_start;
  logic [15:0] tx_data_length, tx_total_length;
  logic [7:0]  drop_cnt;
  logic [1:0]  ctrl_state;

  logic [3:0]  man_tx_state;
  logic [3:0]  emu_tx_state;
  logic        emu_en;

  int n_checks = 0;
  int n_errors = 0;

  udp_loopback_ctrl #(
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .HDR_BYTES   (HDR_BYTES),
    .TX_IDLE     (4'd0),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .MIN_GAP     (MIN_GAP)
  ) dut (
    .e_rxc           (e_rxc),
    .reset_n         (reset_n),
    .data_receive    (data_receive),
    .rx_data_length  (rx_data_length),
    .rx_total_length (rx_total_length),
    .tx_state        (tx_state),
    .wr_bank         (wr_bank),
    .rd_bank         (rd_bank),
    .ram_wr_en       (ram_wr_en),
    .tx_start        (tx_start),
    .tx_data_length  (tx_data_length),
    .tx_total_length (tx_total_length),
    .drop_cnt        (drop_cnt),
    .ctrl_state      (ctrl_state)
  );

  assign tx_state = emu_en ? emu_tx_state : man_tx_state;

  // ---------------- clock / watchdog ----------------
  initial e_rxc = 1'b0;
  always #5 e_rxc = ~e_rxc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  int          pending   = 0;
  int          exp_drop  = 0;
  logic [3:0]  prev_tx_state = 4'd0;

  function automatic bit frame_ok(input int dl, input int tl);
    return (dl >= 1) && (dl <= MAX_PAYLOAD) && (tl == dl + HDR_BYTES);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // A frame is taken whenever fewer than two are pending; a transmission
  // finishes when ipsend goes from busy back to idle.
  always @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      pending       = 0;
      exp_drop      = 0;
      prev_tx_state = 4'd0;
      exp_q.delete();
    end else begin
      bit acc, rel;
      acc = 1'b0;
      rel = (prev_tx_state != 4'd0) && (tx_state == 4'd0);
      if (data_receive) begin
        if (pending < 2 && frame_ok(int'(rx_data_length), int'(rx_total_length))) begin
          acc = 1'b1;
          exp_q.push_back({rx_data_length, rx_total_length});
        end else begin
          exp_drop = sat_inc(exp_drop);
        end
      end
      pending = pending + int'(acc) - int'(rel);
      prev_tx_state = tx_state;
    end
  end

  // Abandoned transmission (no acknowledge): frame leaves the queue, counts as a drop.
  task automatic model_timeout();
    pending  = pending - 1;
    exp_drop = sat_inc(exp_drop);
  endtask

  // ---------------- monitor ----------------
  logic prev_start = 1'b0;
  always @(negedge e_rxc) begin
    if (!reset_n) begin
      prev_start = 1'b0;
    end else begin
      if (tx_start && !prev_start) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tx_start", 1, 0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("tx_data_length", int'(tx_data_length), int'(e[31:16]));
          check("tx_total_length", int'(tx_total_length), int'(e[15:0]));
        end
      end
      prev_start = tx_start;
    end
  end

  // ---------------- ipsend emulator (random phase) ----------------
  initial emu_tx_state = 4'd0;
  always begin
    @(negedge e_rxc);
    if (emu_en && reset_n && tx_start) begin
      repeat ($urandom_range(0, 5)) @(negedge e_rxc);
      emu_tx_state = 4'($urandom_range(1, 15));
      repeat ($urandom_range(1, 20)) @(negedge e_rxc);
      emu_tx_state = 4'd0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a negedge; returns at the negedge following the
  // capture edge of the data_receive pulse.
  task automatic send_frame(input int dl, input int tl);
    data_receive    = 1'b1;
    rx_data_length  = 16'(dl);
    rx_total_length = 16'(tl);
    @(negedge e_rxc);
    data_receive    = 1'b0;
  endtask

  task automatic wait_start(input int max_cycles);
    int n = 0;
    while (!tx_start && n < max_cycles) begin
      @(negedge e_rxc);
      n++;
    end
    if (!tx_start) check("wait_start_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (ctrl_state != 2'd0 && n < max_cycles) begin
      @(negedge e_rxc);
      n++;
    end
    if (ctrl_state != 2'd0) check("wait_idle_timeout", int'(ctrl_state), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_bank"}, int'(wr_bank), 0);
    check({tag, "_rd_bank"}, int'(rd_bank), 0);
    check({tag, "_ram_wr_en"}, int'(ram_wr_en), 1);
    check({tag, "_tx_start"}, int'(tx_start), 0);
    check({tag, "_tx_data_length"}, int'(tx_data_length), 0);
    check({tag, "_tx_total_length"}, int'(tx_total_length), 0);
    check({tag, "_drop_cnt"}, int'(drop_cnt), 0);
    check({tag, "_ctrl_state"}, int'(ctrl_state), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    reset_n         = 1'b0;
    data_receive    = 1'b0;
    rx_data_length  = 16'd0;
    rx_total_length = 16'd0;
    man_tx_state    = 4'd0;
    emu_en          = 1'b0;
    repeat (3) @(negedge e_rxc);
    reset_n = 1'b1;
    @(negedge e_rxc);
    check_reset_outputs("reset");

    // T1: single frame, start latency and release
    send_frame(18, 46);
    check("t1_start_at_cycle1", int'(tx_start), 0);
    @(negedge e_rxc);
    check("t1_start_at_cycle2", int'(tx_start), 1);
    check("t1_state_start", int'(ctrl_state), 1);
    man_tx_state = 4'd3;
    @(negedge e_rxc);
    check("t1_start_falls", int'(tx_start), 0);
    check("t1_state_busy", int'(ctrl_state), 2);
    repeat (3) @(negedge e_rxc);
    man_tx_state = 4'd0;
    @(negedge e_rxc);
    check("t1_rd_bank", int'(rd_bank), 1);
    check("t1_state_gap", int'(ctrl_state), 3);
    check("t1_ram_wr_en", int'(ram_wr_en), 1);
    wait_idle(100);

    // T2/T3: A transmitting, B queued, C rejected with both banks full
    send_frame(100, 128);
    wait_start(10);
    man_tx_state = 4'd5;
    @(negedge e_rxc);
    send_frame(200, 228);
    check("t2_ram_wr_en_full", int'(ram_wr_en), 0);
    check("t2_wr_bank", int'(wr_bank), 1);
    @(negedge e_rxc);
    send_frame(300, 328);
    check("t3_drop_cnt", int'(drop_cnt), 1);
    check("t3_wr_bank_kept", int'(wr_bank), 1);
    check("t3_tx_len_kept", int'(tx_data_length), 100);
    man_tx_state = 4'd0;
    cnt = 0;
    while (!tx_start && cnt < 60) begin
      @(negedge e_rxc);
      cnt++;
    end
    check("t2_gap_latency", cnt, MIN_GAP + 2);
    check("t2_b_data_length", int'(tx_data_length), 200);
    man_tx_state = 4'd2;
    repeat (3) @(negedge e_rxc);
    man_tx_state = 4'd0;
    @(negedge e_rxc);
    check("t2_rd_bank", int'(rd_bank), 1);
    wait_idle(100);

    // T4: invalid lengths, including 16-bit wrap of payload+header
    begin
      int bad_dl[4] = '{0, 1500, 100, 65535};
      int bad_tl[4] = '{28, 1528, 129, 27};
      for (int i = 0; i < 4; i++) begin
        send_frame(bad_dl[i], bad_tl[i]);
        check("t4_drop_cnt", int'(drop_cnt), 2 + i);
        check("t4_wr_bank", int'(wr_bank), 1);
        @(negedge e_rxc);
      end
      check("t4_state_idle", int'(ctrl_state), 0);
    end

    // T5: max payload accepted, ipsend never acknowledges
    send_frame(MAX_PAYLOAD, MAX_PAYLOAD + HDR_BYTES);
    wait_start(10);
    cnt = 0;
    while (ctrl_state != 2'd3 && cnt < ACK_TIMEOUT + 50) begin
      @(negedge e_rxc);
      cnt++;
    end
    model_timeout();
    check("t5_timeout_cycles", cnt, ACK_TIMEOUT);
    check("t5_drop_cnt", int'(drop_cnt), 6);
    check("t5_drop_model", int'(drop_cnt), exp_drop);
    check("t5_rd_bank", int'(rd_bank), 0);
    check("t5_tx_start_low", int'(tx_start), 0);
    wait_idle(100);

    // T5b: drop counter saturation
    for (int i = 0; i < 300; i++) begin
      send_frame(0, HDR_BYTES);
      @(negedge e_rxc);
    end
    check("t5_drop_saturated", int'(drop_cnt), 255);
    check("t5_wr_bank_after_drops", int'(wr_bank), 0);

    // T6: asynchronous reset during BUSY, then normal operation
    send_frame(64, 92);
    wait_start(10);
    man_tx_state = 4'd7;
    @(negedge e_rxc);
    check("t6_state_busy", int'(ctrl_state), 2);
    #2;
    reset_n      = 1'b0;
    man_tx_state = 4'd0;
    #1;
    check_reset_outputs("t6_async_reset");
    repeat (2) @(negedge e_rxc);
    reset_n = 1'b1;
    @(negedge e_rxc);
    send_frame(10, 38);
    check("t6_start_at_cycle1", int'(tx_start), 0);
    @(negedge e_rxc);
    check("t6_start_at_cycle2", int'(tx_start), 1);
    man_tx_state = 4'd1;
    @(negedge e_rxc);
    man_tx_state = 4'd0;
    @(negedge e_rxc);
    check("t6_rd_bank", int'(rd_bank), 1);
    wait_idle(100);

    // Random phase: mixed valid/invalid frames against the emulated ipsend
    emu_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      int kind, dl, tl;
      kind = int'($urandom_range(0, 4));
      dl   = int'($urandom_range(1, MAX_PAYLOAD));
      tl   = dl + HDR_BYTES;
      case (kind)
        1: begin dl = 0; tl = HDR_BYTES; end
        2: begin dl = int'($urandom_range(MAX_PAYLOAD + 1, 65535)); tl = (dl + HDR_BYTES) % 65536; end
        3: tl = dl + HDR_BYTES + int'($urandom_range(1, 3));
        default: ;
      endcase
      send_frame(dl, tl);
      repeat ($urandom_range(1, 30)) @(negedge e_rxc);
    end
    cnt = 0;
    while ((pending != 0 || ctrl_state != 2'd0) && cnt < 3000) begin
      @(negedge e_rxc);
      cnt++;
    end
    check("rand_drained", pending, 0);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_drop_cnt", int'(drop_cnt), exp_drop);
    check("rand_ram_wr_en", int'(ram_wr_en), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
